load_store_unit: RTL and testbench

//   Core-side initiator for the data bus: takes one load/store request from the pipeline,

---
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one pipeline memory request, screens it for
// illegal encodings and misalignment, runs a single bus transfer and
// returns one response (extended load data or a fault cause).
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [1:0]  resp_cause,
  output logic        bus_rd,
  output logic        bus_wd,
  output logic [1:0]  bus_size_out,
  output logic [1:0]  bus_size_in,
  output logic [31:0] bus_addr_out,
  output logic [31:0] bus_addr_in,
  output logic [31:0] bus_data_in,
  input  logic [31:0] bus_data_out,
  input  logic        bus_ready,
  input  logic        bus_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, FAULT} state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_MISALGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b11;

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        cause_q, cause_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              illegal, misalign, xfer;
  logic [1:0]        size;
  logic [31:0]       load_ext, store_data;

  // Screening runs on the incoming request so the verdict is taken in the
  // same cycle it is latched; illegal encodings win over misalignment.
  assign illegal  = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                    (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

  assign size = req_q.funct3[1:0];
  // A transfer completes in any ISSUE cycle where the bus is free.
  assign xfer = (state_q == ISSUE) && bus_ready && !bus_busy;

  // Extend returned load data according to the latched funct3.
  always_comb begin
    load_ext = bus_data_out;
    case (req_q.funct3)
      3'b000:  load_ext = {{24{bus_data_out[7]}},  bus_data_out[7:0]};
      3'b001:  load_ext = {{16{bus_data_out[15]}}, bus_data_out[15:0]};
      3'b100:  load_ext = {24'b0, bus_data_out[7:0]};
      3'b101:  load_ext = {16'b0, bus_data_out[15:0]};
      default: load_ext = bus_data_out;
    endcase
  end

  // Store data occupies the low lanes only; upper bits are forced to zero.
  always_comb begin
    store_data = req_q.wdata;
    case (size)
      2'b00:   store_data = {24'b0, req_q.wdata[7:0]};
      2'b01:   store_data = {16'b0, req_q.wdata[15:0]};
      default: store_data = req_q.wdata;
    endcase
  end

  // Next-state logic: accept/screen in IDLE, wait or time out in ISSUE.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = '0;
    cause_d = cause_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d   = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
          rdata_d = '0;
          if (illegal) begin
            state_d = FAULT;
            cause_d = CAUSE_ILLEGAL;
          end else if (misalign) begin
            state_d = FAULT;
            cause_d = CAUSE_MISALGN;
          end else begin
            state_d = ISSUE;
            cause_d = CAUSE_NONE;
          end
        end
      end
      ISSUE: begin
        if (xfer) begin
          state_d = RESP;
          rdata_d = req_q.we ? 32'b0 : load_ext;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = FAULT;
          cause_d = CAUSE_TIMEOUT;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset also aborts any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP) || (state_q == FAULT);
  assign resp_exc     = (state_q == FAULT);
  assign resp_cause   = (state_q == FAULT) ? cause_q : CAUSE_NONE;
  assign resp_rdata   = (state_q == RESP) ? rdata_q : 32'b0;

  assign bus_rd       = xfer && !req_q.we;
  assign bus_wd       = xfer &&  req_q.we;
  assign bus_size_out = (state_q == ISSUE) ? size : 2'b00;
  assign bus_size_in  = (state_q == ISSUE) ? size : 2'b00;
  assign bus_addr_out = (state_q == ISSUE) ? req_q.addr : 32'b0;
  assign bus_addr_in  = (state_q == ISSUE) ? req_q.addr : 32'b0;
  assign bus_data_in  = (state_q == ISSUE) ? store_data : 32'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed requests push expected responses and
// bus events into queues; a negedge monitor pops and compares them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_exc;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_cause;
  logic        bus_rd, bus_wd;
  logic [1:0]  bus_size_out, bus_size_in;
  logic [31:0] bus_addr_out, bus_addr_in, bus_data_in;
  logic [31:0] bus_data_out = '0;
  logic        bus_ready = 1'b1, bus_busy = 1'b0;

  load_store_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
    .resp_cause(resp_cause),
    .bus_rd(bus_rd), .bus_wd(bus_wd), .bus_size_out(bus_size_out),
    .bus_size_in(bus_size_in), .bus_addr_out(bus_addr_out), .bus_addr_in(bus_addr_in),
    .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
    .bus_ready(bus_ready), .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        exc;
    logic [1:0]  cause;
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } resp_exp_t;

  typedef struct {
    logic        wd;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_exp_t;

  resp_exp_t rq[$];
  bus_exp_t  bq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares each response and each bus strobe against the queues.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (rq.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        resp_exp_t e;
        e = rq.pop_front();
        chk("resp_exc", 32'(resp_exc), 32'(e.exc));
        chk("resp_cause", 32'(resp_cause), 32'(e.cause));
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
    if (bus_rd || bus_wd) begin
      chk("strobe_with_resp", 32'(resp_valid), 32'd0);
      chk("both_strobes", 32'(bus_rd & bus_wd), 32'd0);
      if (bq.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        bus_exp_t b;
        b = bq.pop_front();
        chk("bus_wd", 32'(bus_wd), 32'(b.wd));
        if (b.wd) begin
          chk("bus_size_in", 32'(bus_size_in), 32'(b.size));
          chk("bus_addr_in", bus_addr_in, b.addr);
          chk("bus_data_in", bus_data_in, b.data);
        end else begin
          chk("bus_size_out", 32'(bus_size_out), 32'(b.size));
          chk("bus_addr_out", bus_addr_out, b.addr);
        end
      end
    end
  end

  // Issue one request with hand-computed expectations; strobe: 0 none, 1 rd, 2 wd.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] bdata,
                      input logic exc, input logic [1:0] cause, input logic [31:0] rdata,
                      input int lat, input int strobe, input logic [1:0] bsize,
                      input logic [31:0] bwdata);
    resp_exp_t e;
    bus_exp_t  b;
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_wait", 32'd0, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    bus_data_out = bdata;
    e.exc = exc; e.cause = cause; e.rdata = rdata; e.acc = cyc; e.lat = lat;
    rq.push_back(e);
    if (strobe != 0) begin
      b.wd = (strobe == 2); b.size = bsize; b.addr = addr; b.data = bwdata;
      bq.push_back(b);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 40 && rq.size() != 0; i++) @(negedge clk);
    if (rq.size() != 0) begin
      chk("resp_timeout", 32'(rq.size()), 32'd0);
      rq.delete();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Reset state
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_exc", 32'(resp_exc), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_cause", 32'(resp_cause), 32'd0);
    chk("rst_bus_strobes", 32'({bus_rd, bus_wd}), 32'd0);
    chk("rst_bus_addr", bus_addr_out | bus_addr_in | bus_data_in, 32'd0);
    rst = 1'b0;

    //   we  f3      addr   wdata         bus data      exc cause rdata         lat strb size bwdata
    send(0, 3'b000, 32'h10, 32'h0,        32'h00000080, 0, 2'b00, 32'hFFFFFF80, 2, 1, 2'b00, 32'h0);
    send(0, 3'b101, 32'h12, 32'h0,        32'h0000ABCD, 0, 2'b00, 32'h0000ABCD, 2, 1, 2'b01, 32'h0);
    send(1, 3'b000, 32'h21, 32'h12345678, 32'h0,        0, 2'b00, 32'h0,        2, 2, 2'b00, 32'h00000078);
    send(0, 3'b010, 32'h06, 32'h0,        32'h0,        1, 2'b01, 32'h0,        1, 0, 2'b00, 32'h0);
    send(0, 3'b011, 32'h00, 32'h0,        32'h0,        1, 2'b11, 32'h0,        1, 0, 2'b00, 32'h0);
    send(0, 3'b001, 32'h02, 32'h0,        32'h00008001, 0, 2'b00, 32'hFFFF8001, 2, 1, 2'b01, 32'h0);
    send(1, 3'b010, 32'h04, 32'hDEADBEEF, 32'h0,        0, 2'b00, 32'h0,        2, 2, 2'b10, 32'hDEADBEEF);
    send(1, 3'b001, 32'h02, 32'h12345678, 32'h0,        0, 2'b00, 32'h0,        2, 2, 2'b01, 32'h00005678);
    send(1, 3'b100, 32'h00, 32'h0,        32'h0,        1, 2'b11, 32'h0,        1, 0, 2'b00, 32'h0);
    send(0, 3'b010, 32'h08, 32'h0,        32'hCAFEBABE, 0, 2'b00, 32'hCAFEBABE, 2, 1, 2'b10, 32'h0);
    send(0, 3'b100, 32'h03, 32'h0,        32'h000000F0, 0, 2'b00, 32'h000000F0, 2, 1, 2'b00, 32'h0);
    send(0, 3'b001, 32'h01, 32'h0,        32'h0,        1, 2'b01, 32'h0,        1, 0, 2'b00, 32'h0);
    send(0, 3'b111, 32'h01, 32'h0,        32'h0,        1, 2'b11, 32'h0,        1, 0, 2'b00, 32'h0);

    // Bus held busy: 16 waiting cycles then a timeout fault, no strobe.
    bus_busy = 1'b1;
    send(0, 3'b010, 32'h0C, 32'h0,        32'h0,        1, 2'b10, 32'h0,       17, 0, 2'b00, 32'h0);
    bus_busy = 1'b0;

    // Bus not ready for two cycles after accept; transfer lands in cycle 3.
    bus_ready = 1'b0;
    fork
      send(0, 3'b000, 32'h40, 32'h0,      32'h0000007F, 0, 2'b00, 32'h0000007F, 4, 1, 2'b00, 32'h0);
      begin
        @(negedge clk);
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1 bus_ready = 1'b1;
      end
    join

    // Reset pulsed while waiting in ISSUE: no response for the aborted request.
    bus_busy = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h30;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("issue_req_ready_low", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_strobes", 32'({bus_rd, bus_wd}), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    bus_busy = 1'b0;
    repeat (4) @(negedge clk);

    // Normal operation resumes after the abort.
    send(0, 3'b010, 32'h10, 32'h0,        32'h11223344, 0, 2'b00, 32'h11223344, 2, 1, 2'b10, 32'h0);

    repeat (3) @(negedge clk);
    chk("bus_events_left", 32'(bq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
